clk_div_ctrl: RTL



---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_div_core.sv | 66 ++++++
 rtl/clk_div_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and constants for the clock-divider family.
//   clk_div_state_t : controller state (STOP, RUN, DRAIN)
//   CLK_DIV_WIDTH   : default divisor/counter width
package clk_div_pkg;

  localparam int CLK_DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } clk_div_state_t;

endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: half-period counter, divided-clock toggle flop and the
// divisor-in-effect register.
//   clk, reset       : system clock, synchronous active-high reset
//   en               : count enable; when low the counter is held at 1
//   load, load_div   : write load_div into cur_div at this edge
//   clk_div, tick    : registered divided clock and per-toggle pulse
//   cur_div          : divisor currently in effect
//   wrap             : counter is at its terminal count (not gated by en)
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = CLK_DIV_WIDTH,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_div,
  output logic             clk_div,
  output logic             tick,
  output logic [WIDTH-1:0] cur_div,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] cur_div_r;
  logic             clk_div_r;
  logic             tick_r;

  assign wrap    = (cnt_r == cur_div_r);
  assign clk_div = clk_div_r;
  assign tick    = tick_r;
  assign cur_div = cur_div_r;

  // Counter, toggle flop, tick pulse and divisor register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r     <= ONE;
      clk_div_r <= 1'b0;
      tick_r    <= 1'b0;
      cur_div_r <= WIDTH'(DEFAULT_DIV);
    end else begin
      if (load) begin
        cur_div_r <= load_div;
      end else begin
        cur_div_r <= cur_div_r;
      end
      if (!en) begin
        cnt_r  <= ONE;
        tick_r <= 1'b0;
      end else if (wrap) begin
        // End of a half-period: restart count and flip the output.
        cnt_r     <= ONE;
        clk_div_r <= ~clk_div_r;
        tick_r    <= 1'b1;
      end else begin
        cnt_r  <= cnt_r + ONE;
        tick_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: runtime-programmable clock divider with glitch-free
// start/stop and divisor changes applied only at toggle boundaries.
//   clk, reset          : system clock, synchronous active-high reset
//   enable              : 1 = run, 0 = request clean stop
//   cfg_valid, cfg_div  : divisor offer (0 is clamped to 1)
//   cfg_ready           : no divisor pending, offer will be taken
//   clk_div, tick       : divided clock and per-toggle pulse (registered)
//   running             : controller is in RUN or DRAIN
//   cur_div             : divisor currently in effect
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = CLK_DIV_WIDTH,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             clk_div,
  output logic             tick,
  output logic             running,
  output logic [WIDTH-1:0] cur_div
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  clk_div_state_t   state_r;
  clk_div_state_t   state_s;
  logic             pending_r;
  logic [WIDTH-1:0] pend_div_r;
  logic             running_r;
  logic             core_en_s;
  logic             wrap_s;
  logic             apply_s;
  logic             capture_s;

  clk_div_core #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .en       (core_en_s),
    .load     (apply_s),
    .load_div (pend_div_r),
    .clk_div  (clk_div),
    .tick     (tick),
    .cur_div  (cur_div),
    .wrap     (wrap_s)
  );

  assign cfg_ready = !pending_r;
  assign running   = running_r;
  assign capture_s = cfg_valid && !pending_r;

  // Next-state and counter-enable decode.
  always_comb begin
    state_s   = state_r;
    core_en_s = 1'b0;
    case (state_r)
      STOP: begin
        core_en_s = 1'b0;
        if (enable) begin
          state_s = RUN;
        end else begin
          state_s = STOP;
        end
      end
      RUN: begin
        if (enable) begin
          core_en_s = 1'b1;
          state_s   = RUN;
        end else if (!clk_div) begin
          // Already low: stop at once and suppress the pending rise.
          core_en_s = 1'b0;
          state_s   = STOP;
        end else begin
          // High phase: finish it; if it ends now this toggle is the last.
          core_en_s = 1'b1;
          if (wrap_s) begin
            state_s = STOP;
          end else begin
            state_s = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Only entered while high, so the next toggle drives clk_div low.
        core_en_s = 1'b1;
        if (enable) begin
          state_s = RUN;
        end else if (wrap_s) begin
          state_s = STOP;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        core_en_s = 1'b0;
        state_s   = STOP;
      end
    endcase
  end

  // A pending divisor lands at once when stopped, otherwise on a toggle.
  always_comb begin
    apply_s = 1'b0;
    if (pending_r) begin
      apply_s = (state_r == STOP) || (core_en_s && wrap_s);
    end else begin
      apply_s = 1'b0;
    end
  end

  // State, running flag and pending-divisor register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= STOP;
      running_r  <= 1'b0;
      pending_r  <= 1'b0;
      pend_div_r <= ZERO;
    end else begin
      state_r   <= state_s;
      running_r <= (state_s != STOP);
      if (capture_s) begin
        pending_r  <= 1'b1;
        pend_div_r <= (cfg_div == ZERO) ? ONE : cfg_div;
      end else if (apply_s) begin
        pending_r  <= 1'b0;
        pend_div_r <= pend_div_r;
      end else begin
        pending_r  <= pending_r;
        pend_div_r <= pend_div_r;
      end
    end
  end

endmodule
